scan_test_ctrl: RTL
===================

// Module: scan_test_ctrl
// PURPOSE
//  Scan-test sequencer that sits directly upstream of the scan-inserted FSM block and drives its
//  scan pins: scan_in -> I, scan_mode -> M, scan_out <- O.
//  Per run: shift a CHAIN_LEN-bit pattern in, apply one functional capture clock, shift the response
//  out, then compare it against an expected value under a care mask.
//  Reports done/pass and the captured vector. Polarity inversion along the chain is compensated in
//  both directions.
// PARAMETERS
//  CHAIN_LEN  3       scan flops in the chain; position 0 is the flop that drives scan_out
//  INV_MASK   3'b010  bit k=1: the path from scan_in to chain position k (and from k to scan_out) is inverted
// PORTS
//  clk        in   1          clock, rising edge
//  n_reset    in   1          asynchronous active-low reset
//  start      in   1          sampled in IDLE/DONE; begins a run
//  pattern    in   CHAIN_LEN  value to load; bit k ends in chain position k
//  expect_v   in   CHAIN_LEN  expected post-capture chain contents
//  care       in   CHAIN_LEN  compare mask; 1 = bit is checked
//  scan_out   in   1          chain tail (block output O)
//  scan_in    out  1          chain head (block input I)
//  scan_mode  out  1          1 = shift, 0 = functional
//  busy       out  1          high from SHIFT_IN through SHIFT_OUT
//  done       out  1          one-cycle pulse; results are valid
//  pass       out  1          ((captured ^ expect_v) & care) == 0; held until the next start
//  captured   out  CHAIN_LEN  de-inverted response; held until the next start
// BEHAVIOUR
//  - Reset (async, n_reset=0): state=IDLE; scan_in, scan_mode, busy, done, pass and captured are all 0.
//    Reset mid-run aborts the run. No done pulse is issued. scan_mode drops to 0 immediately.
//  - All outputs come from registers. No combinational path runs from any input to any output.
//  - FSM states: IDLE -> SHIFT_IN -> CAPTURE -> SHIFT_OUT -> DONE; DONE -> IDLE or SHIFT_IN.
//  - IDLE: scan_mode=0. When start=1, latch pattern, expect_v and care, clear captured and pass,
//    and set k=0.
//  - SHIFT_IN (CHAIN_LEN cycles, k=0..L-1):
//    - scan_mode=1; scan_in = pattern[k] ^ INV_MASK[k]. Position 0 is sent first.
//  - CAPTURE (1 cycle): scan_mode=0, scan_in=0. The chain performs one functional step.
//  - SHIFT_OUT (CHAIN_LEN cycles, k=0..L-1):
//    - scan_mode=1, scan_in=0.
//    - At the end of cycle k, captured[k] <= scan_out ^ INV_MASK[k].
//  - DONE (1 cycle): done=1, scan_mode=0, pass valid. Then:
//    - start=1 -> SHIFT_IN with new latched operands (back-to-back run);
//    - otherwise -> IDLE.
//  - Latency: start is sampled at edge 0 and done is high after edge 2*CHAIN_LEN+1 (edge 7 for L=3).
//  - start is ignored while busy. Inputs are latched only at the start accept, so changing them
//    mid-run has no effect.
//  - Counter k is $clog2(CHAIN_LEN+1) wide. It wraps to 0 on each state change and never exceeds
//    CHAIN_LEN-1.
// CONFIGURATION
//  SCAN_ERRCNT_EN defined:
//    - Adds port err_cnt (out, 8 bits).
//    - err_cnt increments on each done with pass=0 and saturates at 255.
//    - Cleared only by n_reset.
//  SCAN_ERRCNT_EN undefined: port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  Package scan_pkg:
//    - scan_state_e (IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE);
//    - SCAN_CHAIN_LEN_DEF=3, SCAN_INV_MASK_DEF=3'b010, ERRCNT_W=8.
//  Sub-module scan_resp_reg:
//    - CHAIN_LEN-bit capture register with per-bit load enable and de-inversion;
//    - masked compare producing pass.
//  The FSM, counter and operand latches stay in scan_test_ctrl.
// TESTING
//  Bench model: 3-flop chain; shift path inverts at position 1; capture holds state unless noted.
//  1 Reset: drive n_reset=0 mid-cycle -> all outputs 0 asynchronously. Release -> IDLE, scan_mode=0.
//  2 Load/unload: pattern=3'b101, expect_v=3'b101, care=3'b111 -> scan_in 1,1,1 over 3 cycles;
//    CAPTURE shows scan_mode=0; done after edge 7; captured=3'b101; pass=1.
//  3 Mismatch: pattern=3'b010, expect_v=3'b011, care=3'b111 -> pass=0.
//    Same run with care=3'b110 -> pass=1.
//  4 Start hold: start held high -> start pulses during busy are ignored; the run after DONE
//    enters SHIFT_IN directly with no IDLE cycle.
//  5 Abort: assert n_reset during SHIFT_OUT k=1 -> scan_mode=0 at once, no done pulse, captured=0.
//    A new start then runs cleanly.
//  6 SCAN_ERRCNT_EN: 3 failing runs -> err_cnt=3. 260 failing runs -> err_cnt=255.
//    A passing run leaves the count unchanged.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan-test sequencer.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } scan_state_e;

  localparam int          SCAN_CHAIN_LEN_DEF = 3;
  localparam logic [2:0]  SCAN_INV_MASK_DEF  = 3'b010;
  localparam int          ERRCNT_W           = 8;

endpackage

// File: rtl/scan_resp_reg.sv
// Response capture register: per-bit load with de-inversion, plus a registered masked compare.
module scan_resp_reg
  import scan_pkg::*;
#(
  parameter int                   CHAIN_LEN = SCAN_CHAIN_LEN_DEF,
  parameter logic [CHAIN_LEN-1:0] INV_MASK  = CHAIN_LEN'(SCAN_INV_MASK_DEF)
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 i_clear,
  input  logic [CHAIN_LEN-1:0] i_load_en,
  input  logic                 i_eval,
  input  logic                 i_scan_out,
  input  logic [CHAIN_LEN-1:0] i_expect,
  input  logic [CHAIN_LEN-1:0] i_care,
  output logic [CHAIN_LEN-1:0] o_captured,
  output logic                 o_pass
);

  logic [CHAIN_LEN-1:0] r_cap;
  logic [CHAIN_LEN-1:0] w_cap_next;
  logic                 r_pass;

  always_comb begin
    w_cap_next = r_cap;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      if (i_load_en[i]) w_cap_next[i] = i_scan_out ^ INV_MASK[i];
    end
  end

  // pass is judged on the vector including the bit loaded this cycle
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cap  <= '0;
      r_pass <= 1'b0;
    end else if (i_clear) begin
      r_cap  <= '0;
      r_pass <= 1'b0;
    end else begin
      r_cap <= w_cap_next;
      if (i_eval) r_pass <= (((w_cap_next ^ i_expect) & i_care) == '0);
    end
  end

  assign o_captured = r_cap;
  assign o_pass     = r_pass;

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer: shift in, one capture clock, shift out, masked compare.
// Optional saturating failure counter on port err_cnt when SCAN_ERRCNT_EN is defined.
module scan_test_ctrl
  import scan_pkg::*;
#(
  parameter int                   CHAIN_LEN = SCAN_CHAIN_LEN_DEF,
  parameter logic [CHAIN_LEN-1:0] INV_MASK  = CHAIN_LEN'(SCAN_INV_MASK_DEF)
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expect_v,
  input  logic [CHAIN_LEN-1:0] care,
  input  logic                 scan_out,
  output logic                 scan_in,
  output logic                 scan_mode,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output scan_state_e          o_dbg_state,
  output logic [CHAIN_LEN-1:0] captured
`ifdef SCAN_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]  err_cnt
`endif
);

  localparam int KW = $clog2(CHAIN_LEN + 1);

  // Handshake: start is accepted on any edge where the FSM is in IDLE or DONE; operands are
  // latched on that edge only. done is a one-cycle pulse; pass/captured hold until the next accept.
  scan_state_e          r_state;
  logic [KW-1:0]        r_k;
  logic [CHAIN_LEN-1:0] r_pattern;
  logic [CHAIN_LEN-1:0] r_expect;
  logic [CHAIN_LEN-1:0] r_care;
  logic                 r_scan_in;
  logic                 r_scan_mode;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_next_bit;
  logic [CHAIN_LEN-1:0] w_load_en;
  logic                 w_pass;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_k == KW'(CHAIN_LEN - 1));

  always_comb begin
    w_next_bit = 1'b0;
    for (int i = 1; i < CHAIN_LEN; i++) begin
      if (r_k == KW'(i - 1)) w_next_bit = r_pattern[i] ^ INV_MASK[i];
    end
  end

  always_comb begin
    w_load_en = '0;
    if (r_state == SHIFT_OUT) w_load_en[r_k] = 1'b1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_pattern   <= '0;
      r_expect    <= '0;
      r_care      <= '0;
      r_scan_in   <= 1'b0;
      r_scan_mode <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_pattern   <= pattern;
            r_expect    <= expect_v;
            r_care      <= care;
            r_k         <= '0;
            r_state     <= SHIFT_IN;
            r_scan_mode <= 1'b1;
            r_busy      <= 1'b1;
            r_scan_in   <= pattern[0] ^ INV_MASK[0];
          end else begin
            r_state     <= IDLE;
            r_scan_mode <= 1'b0;
            r_scan_in   <= 1'b0;
          end
        end
        SHIFT_IN: begin
          if (w_last) begin
            r_state     <= CAPTURE;
            r_k         <= '0;
            r_scan_mode <= 1'b0;
            r_scan_in   <= 1'b0;
          end else begin
            r_k       <= r_k + 1'b1;
            r_scan_in <= w_next_bit;
          end
        end
        CAPTURE: begin
          r_state     <= SHIFT_OUT;
          r_k         <= '0;
          r_scan_mode <= 1'b1;
        end
        SHIFT_OUT: begin
          if (w_last) begin
            r_state     <= DONE;
            r_k         <= '0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_scan_mode <= 1'b0;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_k         <= '0;
          r_scan_mode <= 1'b0;
          r_scan_in   <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  scan_resp_reg #(
    .CHAIN_LEN (CHAIN_LEN),
    .INV_MASK  (INV_MASK)
  ) u_resp (
    .clk        (clk),
    .n_reset    (n_reset),
    .i_clear    (w_accept),
    .i_load_en  (w_load_en),
    .i_eval     ((r_state == SHIFT_OUT) && w_last),
    .i_scan_out (scan_out),
    .i_expect   (r_expect),
    .i_care     (r_care),
    .o_captured (captured),
    .o_pass     (w_pass)
  );

`ifdef SCAN_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_err_cnt <= '0;
    else if (r_done && !w_pass && (r_err_cnt != {ERRCNT_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign err_cnt = r_err_cnt;
`endif

  assign scan_in     = r_scan_in;
  assign scan_mode   = r_scan_mode;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = w_pass;
  assign o_dbg_state = r_state;

endmodule
